// File: rtl/prince_ti_pkg.sv
// Shared types and sizes for the PRINCE threshold-implementation S-box datapath.
package prince_ti_pkg;

  localparam int SHARE_W = 4;
  localparam int TERM_W  = 8;
  localparam int N_TERMS = 4;

  typedef logic [TERM_W-1:0]  term_t;
  typedef logic [SHARE_W-1:0] share_t;

endpackage

// File: rtl/s_bit_compress.sv
// One S-box output bit: folds the eight registered component terms back into two shares.
import prince_ti_pkg::*;

module s_bit_compress (
  input  term_t term,
  output logic  sh1,
  output logic  sh2
);

  // Low nibble carries share-1 terms, high nibble share-2 terms.
  assign sh1 = ^term[3:0];
  assign sh2 = ^term[7:4];

endmodule

// File: rtl/s_share_compress.sv
// Two-stage TI S-box consumer: registered term barrier, then XOR compression into
// two registered 4-bit shares behind a valid/ready handshake.
import prince_ti_pkg::*;

module s_share_compress #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       term1,
  input  logic [7:0]       term2,
  input  logic [7:0]       term3,
  input  logic [7:0]       term4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sh1,
  output logic [3:0]       out_sh2,
  output logic [CNT_W-1:0] acc_cnt
);

  term_t  t_in [N_TERMS];
  term_t  t_q  [N_TERMS];
  logic   v1;
  logic   s2_free;
  logic   in_xfer;
  share_t c_sh1;
  share_t c_sh2;

  assign t_in[0] = term1;
  assign t_in[1] = term2;
  assign t_in[2] = term3;
  assign t_in[3] = term4;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !v1 || s2_free;
  assign in_xfer  = in_valid && in_ready;

  // Stage 1: the only source for the XOR trees, so no input glitch reaches them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < N_TERMS; i++) t_q[i] <= '0;
    end else if (in_xfer) begin
      v1 <= 1'b1;
      for (int i = 0; i < N_TERMS; i++) t_q[i] <= t_in[i];
    end else if (v1 && s2_free) begin
      v1 <= 1'b0;
    end
  end

  for (genvar b = 0; b < N_TERMS; b++) begin : g_bit
    s_bit_compress u_bit (
      .term (t_q[b]),
      .sh1  (c_sh1[b]),
      .sh2  (c_sh2[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sh1   <= '0;
      out_sh2   <= '0;
    end else if (v1 && s2_free) begin
      out_valid <= 1'b1;
      out_sh1   <= c_sh1;
      out_sh2   <= c_sh2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (in_xfer) begin
      acc_cnt <= acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
